count_pwm_compare: RTL and testbench

- Downstream consumer of the free-running 8-bit up-counter output (`count`).
- Compares `count` against an active duty value and drives a registered PWM output.
- Detects counter wrap, emits a wrap pulse and keeps an epoch count.
- Duty updates arrive over a valid/ready handshake. They are held in a shadow register and take effect only at a wrap, so PWM periods are never glitched.
- Checks the incoming count sequence. A discontinuity forces a fault state until the next clean wrap.

---
 rtl/count_pwm_compare.sv | 163 ++++++++++++++++
 tb/tb_count_pwm_compare.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/count_pwm_compare.sv
// ---------------------------------------------------------------------------
// count_pwm_compare
//
// Consumes the value of a free-running up-counter and produces a registered
// PWM output by comparing the counter against an active duty value. Also
// detects counter wrap (MAX -> 0), keeps an epoch count, and checks that the
// incoming sequence increments by exactly one every cycle.
//
// New duty values arrive on a valid/ready handshake. They are parked in a
// shadow register and copied to the active duty only on a wrap cycle, so a
// PWM period never changes duty partway through.
//
// Ports
//   clk          in   1        system clock, rising edge
//   rst          in   1        synchronous active-high reset
//   count        in   CW       upstream counter value
//   duty_in      in   CW       new duty value
//   duty_valid   in   1        duty_in valid
//   duty_ready   out  1        shadow register free (no pending duty)
//   pwm_out      out  1        registered PWM output
//   wrap_pulse   out  1        one-cycle pulse per detected wrap
//   duty_applied out  1        one-cycle pulse when shadow -> active
//   epoch_cnt    out  EPOCH_W  wraps since reset, modulo 2^EPOCH_W
//   seq_err      out  1        sticky sequence-error flag
//   state        out  2        00 IDLE, 01 RUN, 10 FAULT
// ---------------------------------------------------------------------------
module count_pwm_compare #(
    parameter int          CW       = 8,
    parameter int          EPOCH_W  = 16,
    parameter int unsigned DUTY_RST = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CW-1:0]      count,
    input  logic [CW-1:0]      duty_in,
    input  logic               duty_valid,
    output logic               duty_ready,
    output logic               pwm_out,
    output logic               wrap_pulse,
    output logic               duty_applied,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               seq_err,
    output logic [1:0]         state
);

    localparam logic [CW-1:0]      MAX       = '1;
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);
    localparam logic [CW-1:0]      DUTY_INIT = CW'(DUTY_RST);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t        cur_state, nxt_state;

    logic [CW-1:0] prev_count;
    logic          prev_vld;
    logic [CW-1:0] duty_shadow;
    logic [CW-1:0] duty_active;
    logic          pend;

    logic          seq_ok;
    logic          wrap;
    logic          accept;
    logic          apply;
    logic [CW-1:0] duty_eff;
    logic          pwm_nxt;

    // -----------------------------------------------------------------------
    // Sequence tracking. prev_vld masks the first sample after reset, where
    // there is no previous value to compare against.
    // -----------------------------------------------------------------------
    assign seq_ok = !prev_vld || (count == prev_count + CNT_ONE);
    assign wrap   = prev_vld && (prev_count == MAX) && (count == '0);

    // -----------------------------------------------------------------------
    // Duty handshake. accept needs pend=0 and apply needs pend=1, so the two
    // never fire together: a value accepted on a wrap cycle waits for the
    // following wrap.
    // -----------------------------------------------------------------------
    assign duty_ready = !pend;
    assign accept     = duty_valid && !pend;
    assign apply      = wrap && pend;

    // On the apply cycle the comparator already uses the incoming value so
    // the very first count of the new period sees the new duty.
    assign duty_eff = apply ? duty_shadow : duty_active;

    // -----------------------------------------------------------------------
    // FSM next state. A legal wrap is always seq_ok, so RUN never leaves on
    // the wrap cycle itself.
    // -----------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            IDLE:    if (wrap)    nxt_state = RUN;
            RUN:     if (!seq_ok) nxt_state = FAULT;
            FAULT:   if (wrap)    nxt_state = RUN;
            default:              nxt_state = IDLE;
        endcase
    end

    // PWM is forced low whenever the block will not be in RUN next cycle.
    assign pwm_nxt = (nxt_state == RUN) && (count < duty_eff);

    // -----------------------------------------------------------------------
    // Unreset datapath: prev_count follows count unconditionally (prev_vld
    // gates its use), and the shadow is only read while pend is set.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        prev_count <= count;
        if (accept) begin
            duty_shadow <= duty_in;
        end
    end

    // -----------------------------------------------------------------------
    // Control state and registered outputs. Reset wins over every event,
    // including a coincident wrap or a pending duty.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= IDLE;
            prev_vld     <= 1'b0;
            pend         <= 1'b0;
            duty_active  <= DUTY_INIT;
            pwm_out      <= 1'b0;
            wrap_pulse   <= 1'b0;
            duty_applied <= 1'b0;
            epoch_cnt    <= '0;
            seq_err      <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            prev_vld     <= 1'b1;
            pwm_out      <= pwm_nxt;
            wrap_pulse   <= wrap;
            duty_applied <= apply;

            if (apply) begin
                duty_active <= duty_shadow;
                pend        <= 1'b0;
            end else if (accept) begin
                pend        <= 1'b1;
            end

            // Wraps are counted in every state; natural modulo rollover.
            if (wrap) begin
                epoch_cnt <= epoch_cnt + EPOCH_ONE;
            end

            // Any discontinuity, in any state, latches the error flag.
            if (!seq_ok) begin
                seq_err <= 1'b1;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_count_pwm_compare.sv
// ---------------------------------------------------------------------------
// tb_count_pwm_compare
//
// Directed bench for count_pwm_compare. Inputs change 1 time unit after each
// rising edge; outputs are checked at the same point, so each check sees the
// result of the cycle whose count was just driven.
// ---------------------------------------------------------------------------
module tb_count_pwm_compare;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  count;
    logic [7:0]  duty_in;
    logic        duty_valid;
    logic        duty_ready;
    logic        pwm_out;
    logic        wrap_pulse;
    logic        duty_applied;
    logic [15:0] epoch_cnt;
    logic        seq_err;
    logic [1:0]  state;

    int n_tests   = 0;
    int n_fail    = 0;
    int exp_epoch = 0;

    always #5 clk = ~clk;

    count_pwm_compare #(
        .CW       (8),
        .EPOCH_W  (16),
        .DUTY_RST (128)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .count        (count),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .duty_applied (duty_applied),
        .epoch_cnt    (epoch_cnt),
        .seq_err      (seq_err),
        .state        (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [7:0] c);
        count = c;
        @(posedge clk);
        #1;
    endtask

    // One full RUN period starting at the wrap (count=0). Optionally offers a
    // duty value at count inj_at (-1 = none).
    task automatic run_period(input string tag, input int duty, input bit exp_apply,
                              input int inj_at, input int inj_val);
        for (int c = 0; c < 256; c++) begin
            if (c == inj_at) begin
                duty_in    = 8'(inj_val);
                duty_valid = 1'b1;
            end
            tick(8'(c));
            duty_valid = 1'b0;
            if (c == 0) begin
                exp_epoch++;
                chk({tag, ".wrap"},    32'(wrap_pulse),   32'd1);
                chk({tag, ".state"},   32'(state),        32'd1);
                chk({tag, ".epoch"},   32'(epoch_cnt),    32'(exp_epoch));
                chk({tag, ".applied"}, 32'(duty_applied), 32'(exp_apply));
                if (exp_apply && inj_at != 0)
                    chk({tag, ".ready_wrap"}, 32'(duty_ready), 32'd1);
            end else if (c == 1) begin
                chk({tag, ".wrap_end"},    32'(wrap_pulse),   32'd0);
                chk({tag, ".applied_end"}, 32'(duty_applied), 32'd0);
            end
            if (c == inj_at)
                chk({tag, ".ready_low"}, 32'(duty_ready), 32'd0);
            chk({tag, ".pwm"}, 32'(pwm_out), 32'(c < duty));
        end
    endtask

    initial begin
        rst        = 1'b1;
        count      = 8'd0;
        duty_in    = 8'd0;
        duty_valid = 1'b0;

        // Reset state
        tick(8'd0);
        chk("rst.pwm",     32'(pwm_out),      32'd0);
        chk("rst.wrap",    32'(wrap_pulse),   32'd0);
        chk("rst.applied", 32'(duty_applied), 32'd0);
        chk("rst.epoch",   32'(epoch_cnt),    32'd0);
        chk("rst.seq_err", 32'(seq_err),      32'd0);
        chk("rst.state",   32'(state),        32'd0);
        chk("rst.ready",   32'(duty_ready),   32'd1);
        rst = 1'b0;

        // IDLE through the first 256 counts
        for (int c = 0; c < 256; c++) begin
            tick(8'(c));
            chk("idle.state", 32'(state),   32'd0);
            chk("idle.pwm",   32'(pwm_out), 32'd0);
        end
        chk("idle.seq_err", 32'(seq_err), 32'd0);

        // First RUN period at reset duty; offer 64 at count 40
        run_period("p128", 128, 1'b0, 40, 64);
        // 64 applied at wrap; offer 0
        run_period("p64", 64, 1'b1, 100, 0);
        // duty 0: never high; offer 255
        run_period("p0", 0, 1'b1, 50, 255);
        // duty 255: low only at count 255
        run_period("p255", 255, 1'b1, -1, 0);

        // Discontinuity 10 -> 20 in RUN
        tick(8'd0);
        exp_epoch++;
        chk("flt.wrap",  32'(wrap_pulse), 32'd1);
        chk("flt.epoch", 32'(epoch_cnt),  32'(exp_epoch));
        for (int c = 1; c <= 10; c++) begin
            tick(8'(c));
            chk("flt.pre_pwm", 32'(pwm_out), 32'd1);
        end
        tick(8'd20);
        chk("flt.state",   32'(state),   32'd2);
        chk("flt.pwm",     32'(pwm_out), 32'd0);
        chk("flt.seq_err", 32'(seq_err), 32'd1);
        for (int c = 21; c < 256; c++) begin
            tick(8'(c));
            chk("flt.hold_state", 32'(state),   32'd2);
            chk("flt.hold_pwm",   32'(pwm_out), 32'd0);
        end

        // Recovery at wrap; duty 32 offered on the wrap cycle itself
        run_period("resume", 255, 1'b0, 0, 32);
        chk("resume.seq_err", 32'(seq_err), 32'd1);
        // Deferred 32 applied at the following wrap
        run_period("p32", 32, 1'b1, -1, 0);

        // Reset mid-run with a pending duty
        for (int c = 0; c < 100; c++) begin
            if (c == 50) begin
                duty_in    = 8'd200;
                duty_valid = 1'b1;
            end
            tick(8'(c));
            duty_valid = 1'b0;
            if (c == 0) begin
                exp_epoch++;
                chk("pre_rst.wrap",    32'(wrap_pulse),   32'd1);
                chk("pre_rst.applied", 32'(duty_applied), 32'd0);
                chk("pre_rst.epoch",   32'(epoch_cnt),    32'(exp_epoch));
            end
            if (c == 50)
                chk("pre_rst.ready", 32'(duty_ready), 32'd0);
        end
        rst = 1'b1;
        tick(8'd100);
        rst = 1'b0;
        exp_epoch = 0;
        chk("mrst.pwm",     32'(pwm_out),      32'd0);
        chk("mrst.wrap",    32'(wrap_pulse),   32'd0);
        chk("mrst.applied", 32'(duty_applied), 32'd0);
        chk("mrst.epoch",   32'(epoch_cnt),    32'd0);
        chk("mrst.seq_err", 32'(seq_err),      32'd0);
        chk("mrst.state",   32'(state),        32'd0);
        chk("mrst.ready",   32'(duty_ready),   32'd1);

        // Held count in IDLE: seq_err set, state unchanged
        tick(8'd0);
        chk("held.first_ok", 32'(seq_err), 32'd0);
        tick(8'd0);
        chk("held.seq_err", 32'(seq_err), 32'd1);
        chk("held.state",   32'(state),   32'd0);
        for (int c = 1; c < 256; c++) begin
            tick(8'(c));
            chk("held.idle_pwm", 32'(pwm_out), 32'd0);
        end

        // duty_active back at 128, pending value discarded
        run_period("post", 128, 1'b0, -1, 0);
        chk("post.seq_err", 32'(seq_err), 32'd1);
        chk("post.ready",   32'(duty_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
